// File: rtl/pal_pkg.sv
// Shared definitions for the radix palindrome analyzer: FSM encodings,
// width helpers and the elaboration-time depth check.
package pal_pkg;

  localparam int RADIX_MIN = 2;
  localparam int RADIX_MAX = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXTRACT = 2'd1;
  localparam logic [1:0] ST_COMPARE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  function automatic int digit_width(input int radix);
    return (radix <= 2) ? 1 : $clog2(radix);
  endfunction

  function automatic int count_width(input int max_digits);
    return $clog2(max_digits + 1);
  endfunction

  function automatic int index_width(input int max_digits);
    return (max_digits <= 2) ? 1 : $clog2(max_digits);
  endfunction

  // True when max_digits radix digits can hold any width-bit unsigned value.
  function automatic bit digits_cover(input int width, input int radix, input int max_digits);
    logic [127:0] span;
    logic [127:0] limit;
    span  = 128'd1;
    limit = 128'd1 << width;
    for (int i = 0; i < max_digits; i++) begin
      span = span * 128'(radix);
      if (span >= limit) return 1'b1;
    end
    return (span >= limit);
  endfunction

endpackage

// File: rtl/pal_digit_extractor.sv
// Working register plus divide/modulo-by-RADIX datapath; peels one
// least-significant digit per step.
module pal_digit_extractor
  import pal_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RADIX = 10
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          i_load,
  input  logic [WIDTH-1:0]              i_value,
  input  logic                          i_step,
  output logic [digit_width(RADIX)-1:0] o_digit,
  output logic                          o_quot_zero
);

  localparam int DW = digit_width(RADIX);

  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] w_quot;

  // Constant divisor, so synthesis reduces these to fixed logic.
  assign w_quot      = r_work / WIDTH'(RADIX);
  assign o_digit     = DW'(r_work % WIDTH'(RADIX));
  assign o_quot_zero = (w_quot == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_work <= '0;
    end else if (i_load) begin
      r_work <= i_value;
    end else if (i_step) begin
      r_work <= w_quot;
    end
  end

endmodule

// File: rtl/pal_radix_analyzer.sv
// Radix-N palindrome detector: extracts digits LSD first, then compares
// pairs from both ends, one pair per cycle, with a start/done handshake.
module pal_radix_analyzer
  import pal_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RADIX      = 10,
  parameter int MAX_DIGITS = 10
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                signed_mode,
  input  logic [WIDTH-1:0]                    in_number,
  output logic                                busy,
  output logic                                done,
  output logic                                is_pal,
  output logic [count_width(MAX_DIGITS)-1:0]  digit_count
);

  localparam int DW = digit_width(RADIX);
  localparam int CW = count_width(MAX_DIGITS);
  localparam int IW = index_width(MAX_DIGITS);

  if (RADIX < RADIX_MIN || RADIX > RADIX_MAX) begin : g_bad_radix
    $fatal(1, "pal_radix_analyzer: RADIX %0d outside legal range", RADIX);
  end
  if (!digits_cover(WIDTH, RADIX, MAX_DIGITS)) begin : g_bad_depth
    $fatal(1, "pal_radix_analyzer: MAX_DIGITS %0d too small for WIDTH %0d", MAX_DIGITS, WIDTH);
  end

  logic [1:0]    r_state;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_lo;
  logic [CW-1:0] r_hi;
  logic          r_reject;
  logic          r_busy;
  logic          r_done;
  logic          r_is_pal;
  logic [CW-1:0] r_digit_count;
  logic [DW-1:0] r_digits [MAX_DIGITS];

  logic          w_load;
  logic          w_step;
  logic [DW-1:0] w_digit;
  logic          w_quot_zero;

  assign w_load = (r_state == ST_IDLE) && start;
  assign w_step = (r_state == ST_EXTRACT);

  pal_digit_extractor #(
    .WIDTH (WIDTH),
    .RADIX (RADIX)
  ) u_extractor (
    .clock       (clock),
    .reset       (reset),
    .i_load      (w_load),
    .i_value     (in_number),
    .i_step      (w_step),
    .o_digit     (w_digit),
    .o_quot_zero (w_quot_zero)
  );

  // A rejected negative operand still spends one COMPARE cycle so that its
  // done pulse lands one edge after acceptance, like every other result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_lo          <= '0;
      r_hi          <= '0;
      r_reject      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_is_pal      <= 1'b0;
      r_digit_count <= '0;
      for (int i = 0; i < MAX_DIGITS; i++) r_digits[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_count       <= '0;
            r_lo          <= '0;
            r_hi          <= '0;
            r_is_pal      <= 1'b0;
            r_digit_count <= '0;
            r_busy        <= 1'b1;
            if (signed_mode && in_number[WIDTH-1]) begin
              r_reject <= 1'b1;
              r_state  <= ST_COMPARE;
            end else begin
              r_reject <= 1'b0;
              r_state  <= ST_EXTRACT;
            end
          end
        end
        ST_EXTRACT: begin
          r_digits[r_count[IW-1:0]] <= w_digit;
          r_count                   <= r_count + CW'(1);
          if (w_quot_zero) begin
            r_lo    <= '0;
            r_hi    <= r_count;
            r_state <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (r_reject) begin
            r_state       <= ST_DONE;
            r_done        <= 1'b1;
            r_is_pal      <= 1'b0;
            r_digit_count <= r_count;
          end else if (r_lo >= r_hi) begin
            r_state       <= ST_DONE;
            r_done        <= 1'b1;
            r_is_pal      <= 1'b1;
            r_digit_count <= r_count;
          end else if (r_digits[r_lo[IW-1:0]] != r_digits[r_hi[IW-1:0]]) begin
            r_state       <= ST_DONE;
            r_done        <= 1'b1;
            r_is_pal      <= 1'b0;
            r_digit_count <= r_count;
          end else begin
            r_lo <= r_lo + CW'(1);
            r_hi <= r_hi - CW'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign is_pal      = r_is_pal;
  assign digit_count = r_digit_count;

endmodule

// File: tb/tb_pal_radix_analyzer.sv
// Directed bench for pal_radix_analyzer: a decimal 32-bit instance and a
// binary 8-bit instance, with hand-computed latency and results.
module tb_pal_radix_analyzer;

  logic        clock;
  logic        reset;

  logic        start_a, sm_a;
  logic [31:0] num_a;
  logic        busy_a, done_a, pal_a;
  logic [3:0]  cnt_a;

  logic        start_b, sm_b;
  logic [7:0]  num_b;
  logic        busy_b, done_b, pal_b;
  logic [3:0]  cnt_b;

  logic        sel;
  logic        obs_busy, obs_done, obs_pal;
  logic [3:0]  obs_cnt;

  int n_vec = 0;
  int n_err = 0;

  pal_radix_analyzer #(.WIDTH(32), .RADIX(10), .MAX_DIGITS(10)) u_dut_a (
    .clock(clock), .reset(reset), .start(start_a), .signed_mode(sm_a),
    .in_number(num_a), .busy(busy_a), .done(done_a), .is_pal(pal_a),
    .digit_count(cnt_a)
  );

  pal_radix_analyzer #(.WIDTH(8), .RADIX(2), .MAX_DIGITS(8)) u_dut_b (
    .clock(clock), .reset(reset), .start(start_b), .signed_mode(sm_b),
    .in_number(num_b), .busy(busy_b), .done(done_b), .is_pal(pal_b),
    .digit_count(cnt_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    obs_busy = busy_a;
    obs_done = done_a;
    obs_pal  = pal_a;
    obs_cnt  = cnt_a;
    if (sel) begin
      obs_busy = busy_b;
      obs_done = done_b;
      obs_pal  = pal_b;
      obs_cnt  = cnt_b;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic sm, input logic [31:0] num);
    if (sel) begin
      start_b = st; sm_b = sm; num_b = num[7:0];
    end else begin
      start_a = st; sm_a = sm; num_a = num;
    end
  endtask

  // Edge 0 is the edge that accepts start. Inputs are scrambled while busy;
  // with hold>0 start stays high through edge 'hold' and must be ignored.
  task automatic run_op(input string tag, input logic use_b, input logic sm,
                        input logic [31:0] num, input int hold,
                        input int exp_lat, input logic exp_pal, input int exp_cnt);
    int lat;
    lat = -1;
    sel = use_b;
    drive(1'b1, sm, num);
    @(posedge clock); #1;
    chk({tag, ".busy"}, 64'(obs_busy), 64'd1);
    drive(hold > 0, ~sm, ~num);
    for (int e = 1; e <= 80; e++) begin
      @(posedge clock); #1;
      if (e == hold) drive(1'b0, ~sm, ~num);
      if (obs_done) begin
        lat = e;
        break;
      end
    end
    drive(1'b0, sm, num);
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".is_pal"}, 64'(obs_pal), 64'(exp_pal));
    chk({tag, ".count"}, 64'(obs_cnt), 64'(exp_cnt));
    @(posedge clock); #1;
    chk({tag, ".done_1cyc"}, 64'(obs_done), 64'd0);
    chk({tag, ".idle"}, 64'(obs_busy), 64'd0);
    chk({tag, ".held"}, 64'(obs_pal), 64'(exp_pal));
  endtask

  initial begin
    int first_done, second_done, n_done, e_idx;
    reset = 1'b1;
    sel = 1'b0;
    start_a = 1'b0; sm_a = 1'b0; num_a = '0;
    start_b = 1'b0; sm_b = 1'b0; num_b = '0;
    #3;
    chk("rst.busy_a", 64'(busy_a), 64'd0);
    chk("rst.done_a", 64'(done_a), 64'd0);
    chk("rst.pal_a",  64'(pal_a),  64'd0);
    chk("rst.cnt_a",  64'(cnt_a),  64'd0);
    chk("rst.busy_b", 64'(busy_b), 64'd0);
    chk("rst.cnt_b",  64'(cnt_b),  64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    //      tag          b     sm    number          hold lat pal cnt
    run_op("d12321",    1'b0, 1'b0, 32'd12321,       0,   8, 1'b1, 5);
    run_op("d1231",     1'b0, 1'b0, 32'd1231,        0,   6, 1'b0, 4);
    run_op("d0",        1'b0, 1'b0, 32'd0,           0,   2, 1'b1, 1);
    run_op("d7",        1'b0, 1'b0, 32'd7,           0,   2, 1'b1, 1);
    run_op("d10",       1'b0, 1'b0, 32'd10,          0,   3, 1'b0, 2);
    run_op("d1221",     1'b0, 1'b0, 32'd1221,        0,   7, 1'b1, 4);
    run_op("d_neg_s",   1'b0, 1'b1, 32'hFFFFFF87,    0,   1, 1'b0, 0);
    run_op("d_neg_u",   1'b0, 1'b0, 32'hFFFFFF87,    0,  11, 1'b0, 10);
    run_op("d_pos_s",   1'b0, 1'b1, 32'd121,         0,   5, 1'b1, 3);
    run_op("d_max_pal", 1'b0, 1'b0, 32'd4294884924,  0,  16, 1'b1, 10);
    run_op("b09",       1'b1, 1'b0, 32'h09,          0,   7, 1'b1, 4);
    run_op("b0B",       1'b1, 1'b0, 32'h0B,          0,   6, 1'b0, 4);
    run_op("bFF",       1'b1, 1'b0, 32'hFF,          0,  13, 1'b1, 8);
    run_op("b81_s",     1'b1, 1'b1, 32'h81,          0,   1, 1'b0, 0);
    run_op("d_busy_st", 1'b0, 1'b0, 32'd12321,       3,   8, 1'b1, 5);

    // Reset while idle clears the held result.
    sel = 1'b0;
    reset = 1'b1;
    #2;
    chk("rst_idle.pal", 64'(pal_a), 64'd0);
    chk("rst_idle.cnt", 64'(cnt_a), 64'd0);
    @(posedge clock); #1 reset = 1'b0;

    // start held high: second run accepted on the edge after DONE->IDLE.
    first_done = -1;
    second_done = -1;
    drive(1'b1, 1'b0, 32'd7);
    @(posedge clock); #1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clock); #1;
      if (done_a) begin
        if (first_done < 0) first_done = e;
        else begin
          second_done = e;
          break;
        end
      end
    end
    drive(1'b0, 1'b0, 32'd7);
    chk("held.first", 64'(first_done), 64'd2);
    chk("held.second", 64'(second_done), 64'd6);
    repeat (3) @(posedge clock);
    #1;

    // Extra start during EXTRACT, then reset before edge 3.
    drive(1'b1, 1'b0, 32'd12321);
    @(posedge clock); #1;
    drive(1'b1, 1'b0, 32'd0);
    e_idx = 0;
    repeat (2) begin
      @(posedge clock); #1;
      e_idx++;
    end
    chk("midrst.busy_pre", 64'(busy_a), 64'd1);
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0);
    #2;
    chk("midrst.busy", 64'(busy_a), 64'd0);
    chk("midrst.done", 64'(done_a), 64'd0);
    chk("midrst.pal",  64'(pal_a),  64'd0);
    chk("midrst.cnt",  64'(cnt_a),  64'd0);
    @(posedge clock); #1 reset = 1'b0;
    n_done = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (done_a || busy_a) n_done++;
    end
    chk("midrst.quiet", 64'(n_done), 64'd0);
    run_op("d_after_rst", 1'b0, 1'b0, 32'd12321, 0, 8, 1'b1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pal_radix_analyzer.md
Name: pal_radix_analyzer

Overview:
Parametrised palindrome detector for integers in any radix 2..16. It extracts the digits of a captured operand one per cycle, least-significant digit first, then compares digit pairs from both ends one pair per cycle. It uses a start/done handshake, reports the digit count, and supports a signed mode. It sits behind the number-analysis control unit and replaces the fixed 32-bit decimal, enable-level analyzer.

Parameters:
WIDTH, 32, operand width in bits
RADIX, 10, digit base; legal range 2..16
MAX_DIGITS, 10, digit storage depth; must satisfy RADIX**MAX_DIGITS >= 2**WIDTH (elaboration-time check, fatal if violated)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; returns block to IDLE
start  input  1  request; sampled only in IDLE
signed_mode  input  1  1 = in_number is two's complement; sampled with start
in_number  input  WIDTH  operand; sampled with start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle result-valid pulse
is_pal  output  1  result; valid from done, held until next accepted start
digit_count  output  $clog2(MAX_DIGITS+1)  number of digits extracted; held like is_pal

Behaviour:
- Reset values: busy=0, done=0, is_pal=0, digit_count=0, state IDLE, digit store cleared.
- States: IDLE, EXTRACT, COMPARE, DONE.
- IDLE: at an edge with start=1 (call it edge 0):
  - Latch in_number into the working register; clear count; clear is_pal and digit_count.
  - If signed_mode=1 and in_number[WIDTH-1]=1: go to DONE with is_pal=0, digit_count=0. done is high after edge 1.
  - Otherwise go to EXTRACT.
- EXTRACT, one edge per digit:
  - digit[count] <= work % RADIX; work <= work / RADIX; count++.
  - Arithmetic is unsigned on WIDTH bits. Each digit is $clog2(RADIX) bits.
  - Leave for COMPARE when the updated work==0. Operand 0 therefore yields exactly one digit, 0.
- COMPARE:
  - lo starts at 0; hi starts at count-1.
  - Each edge, evaluated in this order:
    - If lo>=hi: DONE with is_pal=1.
    - Else if digit[lo]!=digit[hi]: DONE with is_pal=0.
    - Else lo++, hi--.
- DONE: done=1 for exactly one cycle. digit_count=count. Next edge returns to IDLE.
- Latency, for N digits:
  - Palindrome: done high after edge N+floor(N/2)+1.
  - First mismatch at pair j (1-based): done high after edge N+j.
  - Negative operand in signed mode: done high after edge 1.
- start while busy=1 is ignored; no queuing.
- start held high continuously: a new operation begins on the edge after DONE returns to IDLE.
- in_number and signed_mode changing while busy have no effect.
- Reset mid-operation: immediate return to IDLE with all reset values; no done pulse.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package pal_pkg holds:
  - the state enumeration;
  - the digit-width and count-width helper functions;
  - the legal RADIX bounds constant.
- One sub-module, pal_digit_extractor, holds the working register and the divide/modulo-by-RADIX datapath. It produces the digit, the next quotient and a zero flag.
- The FSM, digit store and compare pointers stay in the top module.

Test Plan:
- RADIX=10, start with in_number=12321 -> busy high from edge 1; done pulse after edge 8; is_pal=1; digit_count=5.
- RADIX=10, in_number=1231 -> done after edge 6 (mismatch 3 vs 2 at pair 2); is_pal=0; digit_count=4.
- RADIX=10, in_number=0, then in_number=7 -> each run: done after edge 2; is_pal=1; digit_count=1.
- RADIX=2, WIDTH=8, MAX_DIGITS=8, in_number=8'h09 (1001b) -> done after edge 7; is_pal=1; digit_count=4. Same with in_number=8'h0B -> is_pal=0.
- RADIX=10, signed_mode=1, in_number=-121 -> done after edge 1; is_pal=0; digit_count=0. Same value with signed_mode=0 -> full unsigned analysis of 4294967175 -> is_pal=0; digit_count=10.
- Assert start during EXTRACT, then reset at edge 3 of a 12321 run -> the extra start is ignored; after reset, busy=0, done never pulses, outputs are 0, and the next start runs normally.
